spi_target: RTL and testbench



---
 rtl/spi_target_pkg.sv | 26 ++
 rtl/spi_target_rx_fifo.sv | 48 ++++
 rtl/spi_target.sv | 239 +++++++++++++++++++++++
 tb/tb_spi_target.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_target_pkg.sv
// Shared definitions for the SPI target peripheral: register map, STATUS bit
// positions, FSM state encodings and RX FIFO depth.
package spi_target_pkg;

    localparam logic [5:0] REG_TX_DATA = 6'd0;
    localparam logic [5:0] REG_RX_DATA = 6'd1;
    localparam logic [5:0] REG_STATUS  = 6'd2;

    localparam int unsigned STAT_RX_VALID   = 0;
    localparam int unsigned STAT_TX_PENDING = 1;
    localparam int unsigned STAT_OVERRUN    = 2;
    localparam int unsigned STAT_BUSY       = 3;
    localparam int unsigned STAT_WIDTH16    = 4;
    localparam int unsigned STAT_COUNT_LSB  = 5;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    localparam int unsigned RX_FIFO_DEPTH = 4;

    // Left-justify the TX word so the next MISO bit is always shift_tx[15].
    function automatic logic [15:0] tx_align(input logic [15:0] word, input logic w16);
        return w16 ? word : {word[7:0], 8'h00};
    endfunction

endpackage

// File: rtl/spi_target_rx_fifo.sv
// 16-bit x 4 RX FIFO for spi_target; a push while full is accepted only when a
// pop happens in the same cycle.
module spi_target_rx_fifo
    import spi_target_pkg::*;
(
    input  logic        raw_clk,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic [2:0]  count,
    output logic        full,
    output logic        empty
);

    logic [15:0] mem_q [RX_FIFO_DEPTH];
    logic [1:0]  wr_ptr_q;
    logic [1:0]  rd_ptr_q;
    logic [2:0]  count_q;
    logic        do_push;
    logic        do_pop;

    assign empty   = (count_q == 3'd0);
    assign full    = (count_q == 3'(RX_FIFO_DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge raw_clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + 2'd1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            count_q <= count_q + {2'b00, do_push} - {2'b00, do_pop};
        end
    end

endmodule

// File: rtl/spi_target.sv
// Mode-0 SPI target with bus-mapped TX/RX/STATUS registers.
// Define SPI_TARGET_RX_FIFO_EN for a 4-entry RX FIFO instead of a holding register.
module spi_target
    import spi_target_pkg::*;
(
    input  logic        raw_clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [7:0]  address,
    input  logic [31:0] data_in,
    input  logic        write_enable,
    output logic [31:0] data_out,
    input  logic        sclk,
    input  logic        cs_n,
    input  logic        mosi,
    output logic        miso
);

    logic [2:0]  sclk_q, cs_q, mosi_q;
    logic [1:0]  sync_vld_q;
    logic        cs_armed_q;
    logic        sclk_rise_q, sclk_fall_q, cs_fall_q, cs_rise_q;

    logic [0:0]  state_q, state_d;
    logic [15:0] shift_tx_q, shift_tx_d;
    logic [15:0] shift_rx_q, shift_rx_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic        xfer_w16_q, xfer_w16_d;
    logic        miso_q, miso_d;
    logic [15:0] tx_buffer_q, tx_buffer_d;
    logic        tx_pending_q, tx_pending_d;
    logic        width_16_q, width_16_d;
    logic        overrun_q, overrun_d;
    logic        enable_q;
    logic [31:0] data_out_q, data_out_d;

    logic [5:0]  reg_sel;
    logic        rd_access, wr_access, rx_pop, rx_push;
    logic [15:0] rx_word, rx_rdata;
    logic        rx_valid, rx_full;
    logic [2:0]  rx_count;
    logic [31:0] status_word;
    logic        unused_bits;

    assign reg_sel   = address[7:2];
    assign rd_access = enable & ~write_enable;
    assign wr_access = enable & write_enable;
    assign rx_pop    = rd_access & ~enable_q & (reg_sel == REG_RX_DATA) & rx_valid;
    assign data_out  = data_out_q;
    assign miso      = miso_q & ~cs_n;
    assign unused_bits = ^{address[1:0], data_in[31:16], shift_rx_q[15]};

    // cs_armed_q blocks a falling edge until cs_n has been seen high after reset.
    always_ff @(posedge raw_clk) begin
        if (reset) begin
            sclk_q      <= '0;
            cs_q        <= '1;
            mosi_q      <= '0;
            sync_vld_q  <= '0;
            cs_armed_q  <= 1'b0;
            sclk_rise_q <= 1'b0;
            sclk_fall_q <= 1'b0;
            cs_fall_q   <= 1'b0;
            cs_rise_q   <= 1'b0;
        end else begin
            sclk_q      <= {sclk_q[1:0], sclk};
            cs_q        <= {cs_q[1:0], cs_n};
            mosi_q      <= {mosi_q[1:0], mosi};
            sync_vld_q  <= {sync_vld_q[0], 1'b1};
            cs_armed_q  <= cs_armed_q | (sync_vld_q[1] & cs_q[1]);
            sclk_rise_q <= sclk_q[1] & ~sclk_q[2];
            sclk_fall_q <= ~sclk_q[1] & sclk_q[2];
            cs_fall_q   <= cs_armed_q & ~cs_q[1] & cs_q[2];
            cs_rise_q   <= cs_q[1] & ~cs_q[2];
        end
    end

`ifdef SPI_TARGET_RX_FIFO_EN
    logic rx_empty;

    spi_target_rx_fifo u_rx_fifo (
        .raw_clk (raw_clk),
        .reset   (reset),
        .push    (rx_push),
        .pop     (rx_pop),
        .wdata   (rx_word),
        .rdata   (rx_rdata),
        .count   (rx_count),
        .full    (rx_full),
        .empty   (rx_empty)
    );
    assign rx_valid = ~rx_empty;
`else
    logic [15:0] rx_data_q;
    logic        rx_valid_q;

    always_ff @(posedge raw_clk) begin
        if (reset) begin
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            if (rx_pop) begin
                rx_valid_q <= 1'b0;
            end
            if (rx_push && (!rx_valid_q || rx_pop)) begin
                rx_data_q  <= rx_word;
                rx_valid_q <= 1'b1;
            end
        end
    end
    assign rx_rdata = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rx_full  = rx_valid_q;
    assign rx_count = '0;
`endif

    always_comb begin
        status_word                         = '0;
        status_word[STAT_RX_VALID]          = rx_valid;
        status_word[STAT_TX_PENDING]        = tx_pending_q;
        status_word[STAT_OVERRUN]           = overrun_q;
        status_word[STAT_BUSY]              = (state_q == SHIFT);
        status_word[STAT_WIDTH16]           = width_16_q;
        status_word[STAT_COUNT_LSB +: 3]    = rx_count;
    end

    always_comb begin
        state_d      = state_q;
        shift_tx_d   = shift_tx_q;
        shift_rx_d   = shift_rx_q;
        bit_cnt_d    = bit_cnt_q;
        xfer_w16_d   = xfer_w16_q;
        miso_d       = miso_q;
        tx_buffer_d  = tx_buffer_q;
        tx_pending_d = tx_pending_q;
        width_16_d   = width_16_q;
        overrun_d    = overrun_q;
        rx_push      = 1'b0;
        rx_word      = '0;

        case (state_q)
            IDLE: begin
                if (cs_fall_q) begin
                    state_d      = SHIFT;
                    xfer_w16_d   = width_16_q;
                    shift_tx_d   = tx_align(tx_buffer_q, width_16_q);
                    tx_pending_d = 1'b0;
                    bit_cnt_d    = '0;
                    miso_d       = shift_tx_d[15];
                end
            end
            default: begin
                if (cs_rise_q) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    miso_d    = 1'b0;
                end else if (sclk_rise_q) begin
                    shift_rx_d = {shift_rx_q[14:0], mosi_q[2]};
                    if (bit_cnt_q == (xfer_w16_q ? 4'd15 : 4'd7)) begin
                        rx_push      = 1'b1;
                        rx_word      = xfer_w16_q ? shift_rx_d : {8'h00, shift_rx_d[7:0]};
                        bit_cnt_d    = '0;
                        shift_tx_d   = tx_align(tx_buffer_q, xfer_w16_q);
                        tx_pending_d = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else if (sclk_fall_q) begin
                    // bit_cnt 0 here means a fresh word was just reloaded: present its MSB.
                    if (bit_cnt_q == 4'd0) begin
                        miso_d = shift_tx_q[15];
                    end else begin
                        shift_tx_d = {shift_tx_q[14:0], 1'b0};
                        miso_d     = shift_tx_q[14];
                    end
                end
            end
        endcase

        if (rx_push && rx_full && !rx_pop) begin
            overrun_d = 1'b1;
        end

        if (wr_access) begin
            if (reg_sel == REG_TX_DATA) begin
                tx_buffer_d  = data_in[15:0];
                tx_pending_d = 1'b1;
            end else if (reg_sel == REG_STATUS) begin
                if (data_in[STAT_OVERRUN]) begin
                    overrun_d = 1'b0;
                end
                width_16_d = data_in[STAT_WIDTH16];
            end
        end
    end

    always_comb begin
        data_out_d = data_out_q;
        if (rd_access) begin
            case (reg_sel)
                REG_TX_DATA: data_out_d = {16'h0000, tx_buffer_q};
                REG_RX_DATA: data_out_d = rx_valid ? {16'h0000, rx_rdata} : '0;
                REG_STATUS:  data_out_d = status_word;
                default:     data_out_d = '0;
            endcase
        end
    end

    always_ff @(posedge raw_clk) begin
        if (reset) begin
            state_q      <= IDLE;
            shift_tx_q   <= '0;
            shift_rx_q   <= '0;
            bit_cnt_q    <= '0;
            xfer_w16_q   <= 1'b0;
            miso_q       <= 1'b0;
            tx_buffer_q  <= '0;
            tx_pending_q <= 1'b0;
            width_16_q   <= 1'b0;
            overrun_q    <= 1'b0;
            enable_q     <= 1'b0;
            data_out_q   <= '0;
        end else begin
            state_q      <= state_d;
            shift_tx_q   <= shift_tx_d;
            shift_rx_q   <= shift_rx_d;
            bit_cnt_q    <= bit_cnt_d;
            xfer_w16_q   <= xfer_w16_d;
            miso_q       <= miso_d;
            tx_buffer_q  <= tx_buffer_d;
            tx_pending_q <= tx_pending_d;
            width_16_q   <= width_16_d;
            overrun_q    <= overrun_d;
            enable_q     <= enable;
            data_out_q   <= data_out_d;
        end
    end

endmodule

// File: tb/tb_spi_target.sv
// Scoreboard bench for spi_target: expected bus reads and MISO words are queued
// by the stimulus and checked by independent monitors.
module tb_spi_target;

    logic        raw_clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [7:0]  address;
    logic [31:0] data_in;
    logic        write_enable;
    logic [31:0] data_out;
    logic        sclk;
    logic        cs_n;
    logic        mosi;
    logic        miso;

`ifdef SPI_TARGET_RX_FIFO_EN
    localparam bit FIFO_EN = 1'b1;
`else
    localparam bit FIFO_EN = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];
    logic [15:0] exp_miso_q[$];
    logic [15:0] miso_cap;
    event        miso_done;

    spi_target dut (
        .raw_clk      (raw_clk),
        .reset        (reset),
        .enable       (enable),
        .address      (address),
        .data_in      (data_in),
        .write_enable (write_enable),
        .data_out     (data_out),
        .sclk         (sclk),
        .cs_n         (cs_n),
        .mosi         (mosi),
        .miso         (miso)
    );

    always #5 raw_clk = ~raw_clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] st(input int cnt, input bit w16, input bit busy,
                                       input bit ovr, input bit pend, input bit vld);
        logic [2:0] c;
        c = FIFO_EN ? cnt[2:0] : 3'd0;
        return {24'h0, c, w16, busy, ovr, pend, vld};
    endfunction

    initial begin : read_monitor
        forever begin
            @(posedge raw_clk);
            if (enable === 1'b1 && write_enable === 1'b0) begin
                #1;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_read: got 0x%08h expected none", data_out);
                end else begin
                    check(name_q.pop_front(), data_out, exp_q.pop_front());
                end
            end
        end
    end

    initial begin : miso_monitor
        forever begin
            @(miso_done);
            if (exp_miso_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_miso_word: got 0x%04h expected none", miso_cap);
            end else begin
                check("miso_word", {16'h0, miso_cap}, {16'h0, exp_miso_q.pop_front()});
            end
        end
    end

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic bus_write(input logic [5:0] reg_idx, input logic [31:0] d);
        @(posedge raw_clk);
        #1;
        enable       = 1'b1;
        write_enable = 1'b1;
        address      = {reg_idx, 2'b00};
        data_in      = d;
        @(posedge raw_clk);
        #1;
        enable       = 1'b0;
        write_enable = 1'b0;
        data_in      = '0;
    endtask

    task automatic bus_read(input logic [5:0] reg_idx, input logic [31:0] exp, input string nm);
        exp_q.push_back(exp);
        name_q.push_back(nm);
        @(posedge raw_clk);
        #1;
        enable       = 1'b1;
        write_enable = 1'b0;
        address      = {reg_idx, 2'b00};
        @(posedge raw_clk);
        #1;
        enable = 1'b0;
    endtask

    task automatic cs_low();
        cs_n = 1'b0;
        #80;
    endtask

    task automatic cs_high();
        #50;
        cs_n = 1'b1;
        #100;
    endtask

    // Mode 0 controller: MOSI set while SCLK low, MISO sampled at the rising edge.
    task automatic spi_bits(input logic [15:0] word, input int nbits, input int msb,
                            input bit chk, input logic [15:0] exp_miso);
        logic [15:0] cap;
        cap = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = word[msb - i];
            #50;
            sclk = 1'b1;
            cap  = {cap[14:0], miso};
            #50;
            sclk = 1'b0;
        end
        if (chk) begin
            exp_miso_q.push_back(exp_miso);
            miso_cap = cap;
            -> miso_done;
        end
    endtask

    initial begin : stimulus
        reset        = 1'b1;
        enable       = 1'b0;
        write_enable = 1'b0;
        address      = '0;
        data_in      = '0;
        sclk         = 1'b0;
        cs_n         = 1'b1;
        mosi         = 1'b0;
        repeat (4) @(posedge raw_clk);
        #1;
        reset = 1'b0;
        check("reset_data_out", data_out, 32'h0);
        check("reset_miso", {31'h0, miso}, 32'h0);
        bus_read(REG_STATUS_IDX(), st(0, 0, 0, 0, 0, 0), "reset_status");
        bus_read(6'd0, 32'h0, "reset_tx_data");
        bus_read(6'd1, 32'h0, "reset_rx_empty");
        bus_read(6'd5, 32'h0, "unmapped_offset");

        // 8-bit exchange
        bus_write(6'd0, 32'h0000_00A5);
        bus_read(6'd2, st(0, 0, 0, 0, 1, 0), "t1_status_pending");
        cs_low();
        bus_read(6'd2, st(0, 0, 1, 0, 0, 0), "t1_status_busy");
        spi_bits(16'h003C, 8, 7, 1'b1, 16'h00A5);
        cs_high();
        bus_read(6'd2, st(1, 0, 0, 0, 0, 1), "t1_status_rx_valid");
        bus_read(6'd1, 32'h0000_003C, "t1_rx_data");
        bus_read(6'd2, st(0, 0, 0, 0, 0, 0), "t1_status_after_read");

        // 16-bit exchange
        bus_write(6'd2, 32'h0000_0010);
        bus_write(6'd0, 32'h0000_BEEF);
        bus_read(6'd2, st(0, 1, 0, 0, 1, 0), "t2_status_pending");
        cs_low();
        bus_read(6'd2, st(0, 1, 1, 0, 0, 0), "t2_status_busy");
        spi_bits(16'h1234, 16, 15, 1'b1, 16'hBEEF);
        cs_high();
        bus_read(6'd1, 32'h0000_1234, "t2_rx_data");
        bus_read(6'd0, 32'h0000_BEEF, "t2_tx_readback");
        bus_write(6'd2, 32'h0000_0000);

        bus_write(6'd0, 32'h0000_0055);
`ifdef SPI_TARGET_RX_FIFO_EN
        cs_low();
        for (int b = 1; b <= 5; b++) begin
            spi_bits(16'(b), 8, 7, 1'b1, 16'h0055);
        end
        cs_high();
        bus_read(6'd2, st(4, 0, 0, 1, 0, 1), "t4_status_full_overrun");
        bus_read(6'd1, 32'h01, "t4_rx_0");
        bus_read(6'd1, 32'h02, "t4_rx_1");
        bus_read(6'd1, 32'h03, "t4_rx_2");
        bus_read(6'd1, 32'h04, "t4_rx_3");
        bus_read(6'd1, 32'h00, "t4_rx_empty");
`else
        cs_low();
        spi_bits(16'h0011, 8, 7, 1'b1, 16'h0055);
        spi_bits(16'h0022, 8, 7, 1'b1, 16'h0055);
        cs_high();
        bus_read(6'd2, st(1, 0, 0, 1, 0, 1), "t3_status_overrun");
        bus_read(6'd1, 32'h0000_0011, "t3_rx_kept_first");
`endif
        bus_read(6'd2, st(0, 0, 0, 1, 0, 0), "overrun_sticky");
        bus_write(6'd2, 32'h0000_0004);
        bus_read(6'd2, st(0, 0, 0, 0, 0, 0), "overrun_cleared");

        // abort after 5 bits
        cs_low();
        spi_bits(16'h00FF, 5, 7, 1'b0, 16'h0000);
        cs_high();
        check("abort_miso", {31'h0, miso}, 32'h0);
        bus_read(6'd2, st(0, 0, 0, 0, 0, 0), "abort_status");
        bus_read(6'd1, 32'h0, "abort_no_push");
        cs_low();
        spi_bits(16'h007E, 8, 7, 1'b1, 16'h0055);
        cs_high();
        bus_read(6'd1, 32'h0000_007E, "abort_next_byte");

        // reset mid-transfer with cs_n held low
        bus_write(6'd2, 32'h0000_0010);
        bus_write(6'd0, 32'h0000_00C3);
        bus_read(6'd0, 32'h0000_00C3, "t6_tx_before_reset");
        cs_low();
        spi_bits(16'h00E0, 3, 7, 1'b0, 16'h0000);
        @(posedge raw_clk);
        #1;
        reset = 1'b1;
        repeat (3) @(posedge raw_clk);
        #1;
        reset = 1'b0;
        check("t6_reset_data_out", data_out, 32'h0);
        check("t6_reset_miso", {31'h0, miso}, 32'h0);
        spi_bits(16'h001F, 5, 4, 1'b0, 16'h0000);
        #100;
        bus_read(6'd2, st(0, 0, 0, 0, 0, 0), "t6_status_after_reset");
        bus_read(6'd0, 32'h0, "t6_tx_cleared");
        cs_high();
        cs_low();
        spi_bits(16'h0081, 8, 7, 1'b1, 16'h0000);
        cs_high();
        bus_read(6'd1, 32'h0000_0081, "t6_rx_after_reset");

        repeat (5) @(posedge raw_clk);
        if (exp_q.size() != 0 || exp_miso_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0",
                     exp_q.size() + exp_miso_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    function automatic logic [5:0] REG_STATUS_IDX();
        return 6'd2;
    endfunction

endmodule
